clock_div_prog: RTL

CLOCK_DIV_PROG -- requirements
Module: clock_div_prog

---
 rtl/clock_div_prog_if.sv | 12 +
 rtl/clock_div_prog.sv | 125 ++++++++++++
 2 files changed

// File: rtl/clock_div_prog_if.sv
// Divisor write bus for clock_div_prog: one-cycle strobe, target channel and new half-period value.
interface clock_div_prog_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 16
);
    logic             div_we;
    logic [CH_W-1:0]  div_ch;
    logic [CNT_W-1:0] div_val;

    modport master (output div_we, div_ch, div_val);
    modport slave  (input  div_we, div_ch, div_val);
endinterface

// File: rtl/clock_div_prog.sv
// Programmable multi-channel clock divider: shared prescaler plus NUM_CH shadow-buffered channels.
// Optional define CLOCK_DIV_PROG_SYNC_EN adds sync_i, realigning all channels to phase 0.

module clock_div_prog_ch #(
    parameter int CNT_W    = 16,
    parameter int DIV_INIT = 511
) (
    input  logic             clk_sys_i,
    input  logic             rst_i,
    input  logic             en,
    input  logic             base_tick,
`ifdef CLOCK_DIV_PROG_SYNC_EN
    input  logic             sync,
`endif
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    output logic             clk_q,
    output logic             tick_q
);
    logic [CNT_W-1:0] act, shd, cnt;
    logic [CNT_W-1:0] nxt_act;

    // A write landing in the reload cycle bypasses the shadow so it is not lost for a full period
    assign nxt_act = wr ? wr_val : shd;

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            act    <= CNT_W'(DIV_INIT);
            shd    <= CNT_W'(DIV_INIT);
            cnt    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (wr) shd <= wr_val;
`ifdef CLOCK_DIV_PROG_SYNC_EN
            if (sync) begin
                cnt   <= '0;
                clk_q <= 1'b0;
                act   <= nxt_act;
            end else
`endif
            if (!en) begin
                cnt   <= '0;
                clk_q <= 1'b0;
                if (wr) act <= wr_val;
            end else if (base_tick) begin
                if (cnt == act) begin
                    cnt    <= '0;
                    clk_q  <= ~clk_q;
                    tick_q <= ~clk_q;
                    act    <= nxt_act;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

module clock_div_prog #(
    parameter int FREQ_SYSCLK = 25_000_000,
    parameter int TICK_HZ     = 1024,
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DIV_INIT    = 511
) (
    input  logic              clk_sys_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] ch_en_i,
`ifdef CLOCK_DIV_PROG_SYNC_EN
    input  logic              sync_i,
`endif
    clock_div_prog_if.slave   div_if,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic              base_tick_o
);
    localparam int PRE_DIV = FREQ_SYSCLK / TICK_HZ;
    localparam int PRE_W   = (PRE_DIV > 2) ? $clog2(PRE_DIV) : 1;
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PRE_W-1:0] pre;
    logic             base_tick_q;

    // Tick flag is registered one count early so it is high exactly while pre == PRE_DIV-1
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            pre         <= '0;
            base_tick_q <= 1'b0;
        end else
`ifdef CLOCK_DIV_PROG_SYNC_EN
        if (sync_i) begin
            pre         <= '0;
            base_tick_q <= 1'b0;
        end else
`endif
        begin
            pre         <= (pre == PRE_W'(PRE_DIV - 1)) ? '0 : pre + 1'b1;
            base_tick_q <= (pre == PRE_W'(PRE_DIV - 2));
        end
    end

    assign base_tick_o = base_tick_q;

    // Out-of-range channel numbers simply match no decoder
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_div_prog_ch #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk_sys_i (clk_sys_i),
            .rst_i     (rst_i),
            .en        (ch_en_i[i]),
            .base_tick (base_tick_q),
`ifdef CLOCK_DIV_PROG_SYNC_EN
            .sync      (sync_i),
`endif
            .wr        (div_if.div_we && (div_if.div_ch == CH_W'(i))),
            .wr_val    (div_if.div_val),
            .clk_q     (clk_o[i]),
            .tick_q    (tick_o[i])
        );
    end
endmodule
